// File: rtl/md_pkg.sv
// Shared opcodes, state encoding and latency defaults for the multiply/divide unit.
package md_pkg;

   typedef logic [2:0] md_op_t;

   localparam md_op_t MD_MULT  = 3'b000;
   localparam md_op_t MD_MULTU = 3'b001;
   localparam md_op_t MD_DIV   = 3'b010;
   localparam md_op_t MD_DIVU  = 3'b011;
   localparam md_op_t MD_MTHI  = 3'b100;
   localparam md_op_t MD_MTLO  = 3'b101;
   localparam md_op_t MD_MFHI  = 3'b110;
   localparam md_op_t MD_MFLO  = 3'b111;

   localparam int unsigned MD_MULT_CYCLES = 5;
   localparam int unsigned MD_DIV_CYCLES  = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_t;

endpackage

// File: rtl/md_arith.sv
// Combinational mult/multu/div/divu result, including divide-by-zero and
// signed-overflow rules. i_op is md_op[1:0] (bit1: divide, bit0: unsigned).
module md_arith
   import md_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic             w_signed;
   logic [PW-1:0]    w_a_ext;
   logic [PW-1:0]    w_b_ext;
   logic [PW-1:0]    w_prod;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH-1:0] w_b_safe;
   logic [WIDTH-1:0] w_q_mag;
   logic [WIDTH-1:0] w_r_mag;
   logic [WIDTH-1:0] w_quot;
   logic [WIDTH-1:0] w_rem;
   logic             w_div_zero;
   logic             w_ovf;

   assign w_signed = ~i_op[0];

   // Low 2W bits of the product of sign-extended operands equal the signed product
   assign w_a_ext = {{WIDTH{w_signed & i_a[WIDTH-1]}}, i_a};
   assign w_b_ext = {{WIDTH{w_signed & i_b[WIDTH-1]}}, i_b};
   assign w_prod  = w_a_ext * w_b_ext;

   assign w_a_neg  = w_signed & i_a[WIDTH-1];
   assign w_b_neg  = w_signed & i_b[WIDTH-1];
   assign w_a_mag  = w_a_neg ? (~i_a + WIDTH'(1)) : i_a;
   assign w_b_mag  = w_b_neg ? (~i_b + WIDTH'(1)) : i_b;
   assign w_b_safe = w_div_zero ? WIDTH'(1) : w_b_mag;
   assign w_q_mag  = w_a_mag / w_b_safe;
   assign w_r_mag  = w_a_mag % w_b_safe;
   assign w_quot   = (w_a_neg ^ w_b_neg) ? (~w_q_mag + WIDTH'(1)) : w_q_mag;
   assign w_rem    = w_a_neg ? (~w_r_mag + WIDTH'(1)) : w_r_mag;

   assign w_div_zero = (i_b == '0);
   assign w_ovf      = w_signed & (i_a == MOST_NEG) & (&i_b);

   always_comb begin
      o_hi = '0;
      o_lo = '0;
      if (!i_op[1]) begin
         o_hi = w_prod[PW-1:WIDTH];
         o_lo = w_prod[WIDTH-1:0];
      end else if (w_div_zero) begin
         o_hi = i_a;
         o_lo = '1;
      end else if (w_ovf) begin
         o_hi = '0;
         o_lo = MOST_NEG;
      end else begin
         o_hi = w_rem;
         o_lo = w_quot;
      end
   end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div with fixed latency,
// services mthi/mtlo/mfhi/mflo and raises stall while an operation is in flight.
module md_unit
   import md_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             md_en,
   input  md_op_t           md_op,
   input  logic [WIDTH-1:0] md_a,
   input  logic [WIDTH-1:0] md_b,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] md_rdata
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   md_state_t        r_state;
   md_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] r_pend_hi;
   logic [WIDTH-1:0] r_pend_lo;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] w_res_hi;
   logic [WIDTH-1:0] w_res_lo;
   logic             w_start;
   logic             w_done;
   logic             w_mthi;
   logic             w_mtlo;

   md_arith #(
      .WIDTH (WIDTH)
   ) u_arith (
      .i_op (md_op[1:0]),
      .i_a  (md_a),
      .i_b  (md_b),
      .o_hi (w_res_hi),
      .o_lo (w_res_lo)
   );

   // Next-state: flush beats both a new start and the completion write
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_start     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (md_en && !md_op[2] && !flush) begin
               w_start     = 1'b1;
               w_state_nxt = ST_BUSY;
               w_cnt_nxt   = md_op[1] ? DIV_LOAD : MULT_LOAD;
            end
         end
         ST_BUSY: begin
            if (flush) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == '0) begin
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
      endcase
   end

   assign w_mthi = md_en && !busy && !flush && (md_op == MD_MTHI);
   assign w_mtlo = md_en && !busy && !flush && (md_op == MD_MTLO);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_pend_hi <= '0;
         r_pend_lo <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_start) begin
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
         end
         if (w_done)      r_hi <= r_pend_hi;
         else if (w_mthi) r_hi <= md_a;
         if (w_done)      r_lo <= r_pend_lo;
         else if (w_mtlo) r_lo <= md_a;
      end
   end

   assign busy     = (r_state == ST_BUSY);
   assign stall    = busy && md_en && !flush;
   assign hi       = r_hi;
   assign lo       = r_lo;
   assign md_rdata = (md_op == MD_MFHI) ? r_hi : r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO and busy length are queued at issue
// and checked by a monitor whenever busy falls; a second instance runs 1-cycle latency.
module tb_md_unit;
   import md_pkg::*;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        md_en, flush;
   md_op_t      md_op;
   logic [31:0] md_a, md_b;
   logic        busy, stall;
   logic [31:0] hi, lo, md_rdata;

   logic        en1, flush1;
   md_op_t      op1;
   logic [31:0] a1, b1;
   logic        busy1, stall1;
   logic [31:0] hi1, lo1, rd1;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   bit   busy_q = 1'b0;
   int   busy_run = 0;

   md_unit u_dut (
      .clk      (clk),
      .reset    (reset),
      .md_en    (md_en),
      .md_op    (md_op),
      .md_a     (md_a),
      .md_b     (md_b),
      .flush    (flush),
      .busy     (busy),
      .stall    (stall),
      .hi       (hi),
      .lo       (lo),
      .md_rdata (md_rdata)
   );

   md_unit #(
      .MULT_CYCLES (1),
      .DIV_CYCLES  (1)
   ) u_dut1 (
      .clk      (clk),
      .reset    (reset),
      .md_en    (en1),
      .md_op    (op1),
      .md_a     (a1),
      .md_b     (b1),
      .flush    (flush1),
      .busy     (busy1),
      .stall    (stall1),
      .hi       (hi1),
      .lo       (lo1),
      .md_rdata (rd1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle", 32'(busy), 32'd0);
   endtask

   task automatic run_op(input string name, input md_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input int cyc);
      exp_q.push_back('{name, ehi, elo, cyc});
      md_en = 1'b1; md_op = op; md_a = a; md_b = b;
      @(negedge clk);
      md_en = 1'b0;
      wait_idle(40);
   endtask

   // Monitor: each falling edge of busy retires one scoreboard entry
   always @(negedge clk) begin
      exp_t e;
      if (busy) begin
         busy_run++;
      end else if (busy_q) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: busy fell with no expected entry, hi=%h lo=%h", hi, lo);
         end else begin
            e = exp_q.pop_front();
            chk({e.name, "_hi"}, hi, e.hi);
            chk({e.name, "_lo"}, lo, e.lo);
            if (e.cycles >= 0) chk({e.name, "_busy_cycles"}, 32'(busy_run), 32'(e.cycles));
         end
         busy_run = 0;
      end
      busy_q = busy;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; md_en = 1'b0; md_op = MD_MULT; md_a = '0; md_b = '0; flush = 1'b0;
      en1 = 1'b0; op1 = MD_MULT; a1 = '0; b1 = '0; flush1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // multu with stall only while md_en held
      exp_q.push_back('{"multu", 32'h0000_0001, 32'hFFFF_FFFE, 5});
      md_en = 1'b1; md_op = MD_MULTU; md_a = 32'hFFFF_FFFF; md_b = 32'd2;
      @(negedge clk);
      md_en = 1'b0;
      #1 chk("multu_busy", 32'(busy), 32'd1);
      chk("multu_nostall", 32'(stall), 32'd0);
      md_en = 1'b1; md_op = MD_MFHI;
      #1 chk("multu_stall", 32'(stall), 32'd1);
      md_en = 1'b0;
      wait_idle(20);

      run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      run_op("divu_zero", MD_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 10);
      run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);

      // mflo held in E behind a signed mult
      exp_q.push_back('{"mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF4, 5});
      md_en = 1'b1; md_op = MD_MULT; md_a = 32'd3; md_b = 32'hFFFF_FFFC;
      @(negedge clk);
      md_op = MD_MFLO;
      for (int i = 0; i < 20 && busy; i++) begin
         #1 chk("mflo_stall", 32'(stall), 32'd1);
         @(negedge clk);
      end
      #1 chk("mflo_release", 32'(stall), 32'd0);
      chk("mflo_rdata", md_rdata, 32'hFFFF_FFF4);

      // mthi/mtlo/mfhi while idle, and md_en=0 leaves HI alone
      md_op = MD_MTHI; md_a = 32'h0000_ABCD;
      @(negedge clk);
      md_en = 1'b0;
      chk("mthi_hi", hi, 32'h0000_ABCD);
      chk("mthi_lo", lo, 32'hFFFF_FFF4);
      md_en = 1'b1; md_op = MD_MTLO; md_a = 32'h0000_0055;
      @(negedge clk);
      md_en = 1'b0;
      chk("mtlo_lo", lo, 32'h0000_0055);
      md_en = 1'b1; md_op = MD_MFHI;
      #1 chk("mfhi_rdata", md_rdata, 32'h0000_ABCD);
      md_en = 1'b0; md_op = MD_MTHI; md_a = 32'h0000_1234;
      @(negedge clk);
      chk("noen_hi", hi, 32'h0000_ABCD);

      // flush blocks a would-be start
      md_en = 1'b1; md_op = MD_MULT; md_a = 32'd7; md_b = 32'd9; flush = 1'b1;
      @(negedge clk);
      chk("flush_nostart", 32'(busy), 32'd0);
      flush = 1'b0; md_en = 1'b0;

      // flush in busy cycle 3
      exp_q.push_back('{"flush_mid", 32'h0000_ABCD, 32'h0000_0055, 3});
      md_en = 1'b1; md_op = MD_MULT; md_a = 32'd7; md_b = 32'd9;
      @(negedge clk);
      md_en = 1'b0;
      repeat (2) @(negedge clk);
      flush = 1'b1; md_en = 1'b1; md_op = MD_MFHI;
      #1 chk("flush_stall", 32'(stall), 32'd0);
      @(negedge clk);
      flush = 1'b0; md_en = 1'b0;
      chk("flush_mid_busy", 32'(busy), 32'd0);

      // flush on the completion edge
      exp_q.push_back('{"flush_done", 32'h0000_ABCD, 32'h0000_0055, 5});
      md_en = 1'b1; md_op = MD_MULT; md_a = 32'd7; md_b = 32'd9;
      @(negedge clk);
      md_en = 1'b0;
      repeat (4) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_done_busy", 32'(busy), 32'd0);

      // back-to-back: second start only on the edge after busy falls
      exp_q.push_back('{"b2b_1", 32'd0, 32'd6, 5});
      exp_q.push_back('{"b2b_2", 32'd0, 32'd25, 5});
      md_en = 1'b1; md_op = MD_MULT; md_a = 32'd2; md_b = 32'd3;
      @(negedge clk);
      md_a = 32'd5; md_b = 32'd5;
      #1 chk("b2b_stall", 32'(stall), 32'd1);
      wait_idle(20);
      #1 chk("b2b_gap", 32'(busy), 32'd0);
      @(negedge clk);
      chk("b2b_restart", 32'(busy), 32'd1);
      md_en = 1'b0;
      wait_idle(20);

      // asynchronous reset mid-divide
      exp_q.push_back('{"reset_mid", 32'd0, 32'd0, -1});
      md_en = 1'b1; md_op = MD_DIV; md_a = 32'd100; md_b = 32'd7;
      @(negedge clk);
      md_en = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1 chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_hi", hi, 32'd0);
      chk("arst_lo", lo, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // single-cycle latency instance
      en1 = 1'b1; op1 = MD_MULTU; a1 = 32'd5; b1 = 32'd6;
      @(negedge clk);
      en1 = 1'b0;
      chk("lat1_mul_busy", 32'(busy1), 32'd1);
      @(negedge clk);
      chk("lat1_mul_idle", 32'(busy1), 32'd0);
      chk("lat1_mul_lo", lo1, 32'd30);
      chk("lat1_mul_hi", hi1, 32'd0);
      en1 = 1'b1; op1 = MD_DIV; a1 = 32'd20; b1 = 32'd3;
      @(negedge clk);
      en1 = 1'b0;
      chk("lat1_div_busy", 32'(busy1), 32'd1);
      @(negedge clk);
      chk("lat1_div_idle", 32'(busy1), 32'd0);
      chk("lat1_div_lo", lo1, 32'd6);
      chk("lat1_div_hi", hi1, 32'd2);

      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
